// File: rtl/esm_issue_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : esm_issue_scheduler_if                                     |
// | Brief   : Dispatch/issue bundle between an ESM issue buffer          |
// |           controller and the randomized issue scheduler.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface esm_issue_scheduler_if #(
  parameter int BS   = 16,
  parameter int IDXW = $clog2(BS)
) ();
  logic            flush;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [IDXW-1:0] alloc_index;
  logic [BS-1:0]   ready_in;
  logic            issue_valid;
  logic            issue_ready;
  logic [IDXW-1:0] issue_index;
  logic [IDXW:0]   occupancy;

  // Dispatch / consumer side
  modport master (
    output flush, alloc_valid, ready_in, issue_ready,
    input  alloc_ready, alloc_index, issue_valid, issue_index, occupancy
  );

  // Scheduler side
  modport slave (
    input  flush, alloc_valid, ready_in, issue_ready,
    output alloc_ready, alloc_index, issue_valid, issue_index, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/esm_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : esm_issue_scheduler                                        |
// | Brief   : Tracks occupied ESM buffer slots, grants the lowest free   |
// |           slot to dispatch and issues one ready entry per cycle,     |
// |           chosen uniformly at random with a 16-bit Galois LFSR.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module esm_issue_scheduler #(
  parameter int          BS        = 16,
  parameter int          IDXW      = $clog2(BS),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  esm_issue_scheduler_if.slave  bus
);

  // An all-zero Galois LFSR never leaves zero, so substitute 1.
  localparam logic [15:0] C_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] C_MASK = 16'hB400;

  logic [BS-1:0]   valid_q, valid_d;
  logic [BS-1:0]   pend_q, pend_d;
  logic            issue_valid_q, issue_valid_d;
  logic [IDXW-1:0] issue_index_q, issue_index_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic [BS-1:0]   cand;
  logic [IDXW:0]   ncand;
  logic [IDXW:0]   occ;
  logic [IDXW:0]   k;
  logic [IDXW:0]   seen;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] free_idx;
  logic            free_found;
  logic            take;
  logic            hs;
  logic            alloc_fire;

  // Pending slot is excluded so a held issue is never picked twice.
  assign cand       = valid_q & ~pend_q & bus.ready_in;
  assign take       = !issue_valid_q || bus.issue_ready;
  assign hs         = issue_valid_q && bus.issue_ready;
  assign alloc_fire = bus.alloc_valid && free_found;

  // Scaling the LFSR by the candidate count keeps k strictly below ncand.
  assign k = (IDXW+1)'(({{(IDXW+1){1'b0}}, lfsr_q} * {16'h0000, ncand}) >> 16);

  // Lowest free slot; stays 0 when the buffer is full.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < BS; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDXW'(i);
        free_found = 1'b1;
      end
    end
  end

  // Population counts of occupied slots and of issue candidates.
  always_comb begin
    occ   = '0;
    ncand = '0;
    for (int i = 0; i < BS; i++) begin
      occ   = occ + {{IDXW{1'b0}}, valid_q[i]};
      ncand = ncand + {{IDXW{1'b0}}, cand[i]};
    end
  end

  // Index of the k-th set candidate bit, counted upward from slot 0.
  always_comb begin
    sel  = '0;
    seen = '0;
    for (int i = 0; i < BS; i++) begin
      if (cand[i]) begin
        if (seen == k) begin
          sel = IDXW'(i);
        end
        seen = seen + {{IDXW{1'b0}}, 1'b1};
      end
    end
  end

  // Next state: flush wins over handshake, alloc and a new load.
  always_comb begin
    lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_MASK : 16'h0000);
    valid_d       = valid_q;
    pend_d        = pend_q;
    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;
    if (bus.flush) begin
      valid_d       = '0;
      pend_d        = '0;
      issue_valid_d = 1'b0;
    end else begin
      if (hs) begin
        valid_d[issue_index_q] = 1'b0;
        pend_d[issue_index_q]  = 1'b0;
      end
      if (alloc_fire) begin
        valid_d[free_idx] = 1'b1;
      end
      if (take) begin
        if (ncand != '0) begin
          issue_valid_d = 1'b1;
          issue_index_d = sel;
          pend_d[sel]   = 1'b1;
        end else begin
          issue_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      pend_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      lfsr_q        <= C_SEED;
    end else begin
      valid_q       <= valid_d;
      pend_q        <= pend_d;
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign bus.alloc_ready = free_found;
  assign bus.alloc_index = free_idx;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_index = issue_index_q;
  assign bus.occupancy   = occ;

endmodule
`default_nettype wire

// File: tb/tb_esm_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_esm_issue_scheduler                                     |
// | Brief   : Scoreboard bench for esm_issue_scheduler (BS=16).          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_esm_issue_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  logic [4:0] exp_iss_q[$];

  logic [15:0] m_lfsr;
  logic [15:0] m_valid, m_pend;
  logic        m_iv;
  int          m_idx;
  int          cnt[4];

  esm_issue_scheduler_if #(.BS(16)) bus ();

  esm_issue_scheduler #(.BS(16), .LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR: Galois, mask B400, advances every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic int f_pick(input logic [15:0] c, input logic [15:0] l);
    int n, kk, s, r;
    n = 0; s = 0; r = 0;
    for (int i = 0; i < 16; i++) if (c[i]) n++;
    kk = (int'(l) * n) >> 16;
    for (int i = 0; i < 16; i++) begin
      if (c[i]) begin
        if (s == kk) r = i;
        s++;
      end
    end
    return r;
  endfunction

  function automatic int f_lowfree(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (!v[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    bus.flush = 0; bus.alloc_valid = 0; bus.ready_in = '0; bus.issue_ready = 0;
    rst_n = 0;
    #2;
    total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready: got %0b want 1", bus.alloc_ready); end
    total++; if (bus.alloc_index !== 4'd0) begin bad++; $display("FAIL reset_alloc_index: got %0d want 0", bus.alloc_index); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid: got %0b want 0", bus.issue_valid); end
    total++; if (bus.occupancy !== 5'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    for (int i = 0; i < 16; i++) begin
      int e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_index !== 4'(e)) begin
        bad++; $display("FAIL fill_index: got rdy=%0b idx=%0d want rdy=1 idx=%0d", bus.alloc_ready, bus.alloc_index, e);
      end
      total++; if (bus.occupancy !== 5'(i)) begin bad++; $display("FAIL fill_occ: got %0d want %0d", bus.occupancy, i); end
      bus.alloc_valid = 1;
    end
    @(negedge clk);
    total++; if (bus.occupancy !== 5'd16) begin bad++; $display("FAIL full_occ: got %0d want 16", bus.occupancy); end
    total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", bus.alloc_ready); end
    total++; if (bus.alloc_index !== 4'd0) begin bad++; $display("FAIL full_index: got %0d want 0", bus.alloc_index); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd16) begin
        bad++; $display("FAIL full_idle: got iv=%0b occ=%0d want iv=0 occ=16", bus.issue_valid, bus.occupancy);
      end
    end
    bus.alloc_valid = 0;
  endtask

  task automatic test_single_hold();
    int e;
    @(negedge clk);
    bus.ready_in = 16'h0020; bus.issue_ready = 0;
    exp_q.push_back(5);
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'(e)) begin
      bad++; $display("FAIL single_issue: got iv=%0b idx=%0d want iv=1 idx=%0d", bus.issue_valid, bus.issue_index, e);
    end
    for (int j = 0; j < 10; j++) begin
      if (j == 4) bus.ready_in = 16'h0000;
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd5) begin
        bad++; $display("FAIL single_hold: got iv=%0b idx=%0d want iv=1 idx=5", bus.issue_valid, bus.issue_index);
      end
    end
    bus.issue_ready = 1;
    @(negedge clk);
    bus.issue_ready = 0;
    total++; if (bus.occupancy !== 5'd15) begin bad++; $display("FAIL single_occ: got %0d want 15", bus.occupancy); end
    total++; if (bus.alloc_index !== 4'd5 || bus.alloc_ready !== 1'b1) begin
      bad++; $display("FAIL single_free: got rdy=%0b idx=%0d want rdy=1 idx=5", bus.alloc_ready, bus.alloc_index);
    end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %0b want 0", bus.issue_valid); end
  endtask

  task automatic test_back_to_back();
    int seen_hs;
    @(negedge clk);
    total++; if (bus.alloc_index !== 4'd5) begin bad++; $display("FAIL b2b_refill: got %0d want 5", bus.alloc_index); end
    bus.alloc_valid = 1;
    @(negedge clk);
    bus.alloc_valid = 0;
    total++; if (bus.occupancy !== 5'd16) begin bad++; $display("FAIL b2b_full: got %0d want 16", bus.occupancy); end
    exp_q.push_back(0); exp_q.push_back(1);
    bus.ready_in = 16'h0003; bus.issue_ready = 1;
    seen_hs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.issue_valid) begin
        int hit;
        hit = -1;
        foreach (exp_q[q]) if (exp_q[q] == int'(bus.issue_index)) hit = q;
        seen_hs++;
        total++; if (hit < 0) begin
          bad++; $display("FAIL b2b_index: got %0d want one of remaining {0,1}", bus.issue_index);
        end else exp_q.delete(hit);
      end
    end
    total++; if (seen_hs != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count: got %0d handshakes want 2", seen_hs);
    end
    total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd14) begin
      bad++; $display("FAIL b2b_end: got iv=%0b occ=%0d want iv=0 occ=14", bus.issue_valid, bus.occupancy);
    end
    exp_q.delete();
    bus.ready_in = 16'h0000; bus.issue_ready = 0;
  endtask

  task automatic test_randomness();
    int issues, cyc;
    logic [15:0] c, ov;
    logic        ar;
    int          ai;
    logic [4:0]  e;
    @(negedge clk);
    rst_n = 0;
    #1 rst_n = 1;
    bus.alloc_valid = 1;
    for (int i = 0; i < 16; i++) @(negedge clk);
    total++; if (bus.occupancy !== 5'd16) begin bad++; $display("FAIL rnd_fill: got %0d want 16", bus.occupancy); end
    m_valid = 16'hFFFF; m_pend = '0; m_iv = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    exp_iss_q.delete();
    bus.ready_in = 16'h000F; bus.issue_ready = 1; bus.alloc_valid = 1;
    issues = 0; cyc = 0;
    while (issues < 4000 && cyc < 12000) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (exp_iss_q.size() > 0) begin
        e = exp_iss_q.pop_front();
        total++; if (bus.issue_valid !== e[4] || (e[4] && bus.issue_index !== e[3:0])) begin
          bad++; $display("FAIL rnd_issue: got iv=%0b idx=%0d want iv=%0b idx=%0d", bus.issue_valid, bus.issue_index, e[4], e[3:0]);
        end
      end
      ov = m_valid;
      c  = m_valid & ~m_pend & 16'h000F;
      ar = ~&ov;
      ai = f_lowfree(ov);
      total++; if (bus.alloc_ready !== ar || (ar && bus.alloc_index !== 4'(ai))) begin
        bad++; $display("FAIL rnd_alloc: got rdy=%0b idx=%0d want rdy=%0b idx=%0d", bus.alloc_ready, bus.alloc_index, ar, ai);
      end
      if (m_iv) begin
        total++; if (m_idx > 3 || !ov[m_idx]) begin
          bad++; $display("FAIL rnd_slot: got idx=%0d valid=%0b want idx<4 valid=1", m_idx, ov[m_idx]);
        end
        if (m_idx <= 3) cnt[m_idx]++;
        m_valid[m_idx] = 1'b0; m_pend[m_idx] = 1'b0;
        issues++;
      end
      if (ar) m_valid[ai] = 1'b1;
      if (c != 16'h0) begin
        m_iv = 1; m_idx = f_pick(c, m_lfsr); m_pend[m_idx] = 1'b1;
      end else m_iv = 0;
      exp_iss_q.push_back({m_iv, 4'(m_idx)});
    end
    @(negedge clk);
    while (exp_iss_q.size() > 0) begin
      e = exp_iss_q.pop_front();
      total++; if (bus.issue_valid !== e[4] || (e[4] && bus.issue_index !== e[3:0])) begin
        bad++; $display("FAIL rnd_last: got iv=%0b idx=%0d want iv=%0b idx=%0d", bus.issue_valid, bus.issue_index, e[4], e[3:0]);
      end
    end
    bus.alloc_valid = 0; bus.issue_ready = 0; bus.ready_in = 16'h0000;
    total++; if (issues < 4000) begin bad++; $display("FAIL rnd_budget: got %0d issues want 4000", issues); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cnt[i] < 800 || cnt[i] > 1200) begin
        bad++; $display("FAIL rnd_dist: slot %0d got %0d want 800..1200", i, cnt[i]);
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_index !== 4'd0 || bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
      bad++; $display("FAIL midreset: got rdy=%0b idx=%0d iv=%0b occ=%0d want 1/0/0/0", bus.alloc_ready, bus.alloc_index, bus.issue_valid, bus.occupancy);
    end
    #1 rst_n = 1;
    @(negedge clk);
    bus.alloc_valid = 1; bus.ready_in = 16'h0000;
    @(negedge clk);
    total++; if (bus.alloc_index !== 4'd1) begin bad++; $display("FAIL fl_alloc: got %0d want 1", bus.alloc_index); end
    bus.ready_in = 16'h0001;
    @(negedge clk);
    bus.alloc_valid = 0;
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd0 || bus.occupancy !== 5'd2) begin
      bad++; $display("FAIL fl_pre: got iv=%0b idx=%0d occ=%0d want 1/0/2", bus.issue_valid, bus.issue_index, bus.occupancy);
    end
    @(negedge clk);
    total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_index !== 4'd2 || bus.issue_valid !== 1'b1) begin
      bad++; $display("FAIL fl_setup: got rdy=%0b idx=%0d iv=%0b want 1/2/1", bus.alloc_ready, bus.alloc_index, bus.issue_valid);
    end
    bus.flush = 1; bus.alloc_valid = 1;
    @(negedge clk);
    bus.flush = 0; bus.alloc_valid = 0;
    total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd0 || bus.alloc_index !== 4'd0) begin
      bad++; $display("FAIL flush: got iv=%0b occ=%0d idx=%0d want 0/0/0", bus.issue_valid, bus.occupancy, bus.alloc_index);
    end
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
      bad++; $display("FAIL flush_after: got iv=%0b occ=%0d want 0/0", bus.issue_valid, bus.occupancy);
    end
    bus.ready_in = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_hold();
    test_back_to_back();
    test_randomness();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
